// File: rtl/ddr_sim_memory_pl.sv
// Behavioural DDR stand-in behind a MIG-style user interface: byte-masked write-data FIFO,
// fixed-latency read return, periodic command stalls and a sticky illegal-command flag.
module ddr_sim_memory_pl #(
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 29,
    parameter int MEM_AW       = 12,
    parameter int ADDR_SHIFT   = 2,
    parameter int RD_LAT       = 2,
    parameter int INIT_CYCLES  = 1000,
    parameter int WDF_DEPTH    = 4,
    parameter int STALL_PERIOD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          cmd,
    input  logic                app_en,
    input  logic [ADDR_W-1:0]   app_addr,
    output logic                app_rdy,
    input  logic [DATA_W-1:0]   app_wdf_data,
    input  logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_wren,
    output logic                app_wdf_rdy,
    output logic [DATA_W-1:0]   app_rd_data,
    output logic                app_rd_data_valid,
    output logic                phy_init_done,
    output logic                cmd_err
);

    localparam int  BYTES    = DATA_W / 8;
    localparam int  DEPTH    = 2 ** MEM_AW;
    localparam int  PW       = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
    localparam int  CW       = PW + 1;
    localparam int  ICW      = $clog2(INIT_CYCLES + 1);
    localparam bit  STALL_EN = (STALL_PERIOD >= 2);
    localparam int  SCW      = STALL_EN ? $clog2(STALL_PERIOD) : 1;

    logic [ICW-1:0]    init_cnt_r;
    logic              init_done_r;
    logic [SCW-1:0]    stall_cnt_r;
    logic              stall_s;
    logic              cmd_err_r;

    logic [DATA_W-1:0] wdf_data_r [WDF_DEPTH];
    logic [BYTES-1:0]  wdf_mask_r [WDF_DEPTH];
    logic [PW-1:0]     wdf_wr_ptr_r;
    logic [PW-1:0]     wdf_rd_ptr_r;
    logic [CW-1:0]     wdf_cnt_r;
    logic              wdf_empty_s;
    logic              wdf_full_s;
    logic              push_s;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [MEM_AW-1:0] idx_s;
    logic              is_wr_s;
    logic              is_rd_s;
    logic              accept_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              ill_acc_s;

    logic [RD_LAT-1:0] rd_vld_r;
    logic [DATA_W-1:0] rd_dat_r [RD_LAT];

    // Init counter saturates at INIT_CYCLES; done flag rises on the edge it gets there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_r  <= '0;
            init_done_r <= 1'b0;
        end else begin
            if (init_cnt_r != ICW'(INIT_CYCLES)) begin
                init_cnt_r <= init_cnt_r + 1'b1;
            end
            if (init_cnt_r == ICW'(INIT_CYCLES - 1)) begin
                init_done_r <= 1'b1;
            end
        end
    end

    // Free-running modulo counter once init is done; last phase is the stall cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
        end else if (STALL_EN && init_done_r) begin
            if (stall_cnt_r == SCW'(STALL_PERIOD - 1)) begin
                stall_cnt_r <= '0;
            end else begin
                stall_cnt_r <= stall_cnt_r + 1'b1;
            end
        end
    end

    // Handshake decode; a write command needs data already queued (no same-cycle bypass)
    always_comb begin
        idx_s       = MEM_AW'(app_addr >> ADDR_SHIFT);
        is_wr_s     = (cmd == 3'b000);
        is_rd_s     = (cmd == 3'b001);
        stall_s     = STALL_EN && init_done_r && (stall_cnt_r == SCW'(STALL_PERIOD - 1));
        wdf_empty_s = (wdf_cnt_r == CW'(0));
        wdf_full_s  = (wdf_cnt_r == CW'(WDF_DEPTH));
        app_wdf_rdy = init_done_r & ~wdf_full_s;
        app_rdy     = init_done_r & ~stall_s & ~(app_en & is_wr_s & wdf_empty_s);
        push_s      = app_wdf_wren & app_wdf_rdy;
        accept_s    = app_en & app_rdy;
        wr_acc_s    = accept_s & is_wr_s;
        rd_acc_s    = accept_s & is_rd_s;
        ill_acc_s   = accept_s & ~is_wr_s & ~is_rd_s;
    end

    // FIFO storage needs no reset: emptiness is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            wdf_data_r[wdf_wr_ptr_r] <= app_wdf_data;
            wdf_mask_r[wdf_wr_ptr_r] <= app_wdf_mask;
        end
    end

    // FIFO pointers and occupancy; an accepted write command is the pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdf_wr_ptr_r <= '0;
            wdf_rd_ptr_r <= '0;
            wdf_cnt_r    <= '0;
        end else begin
            if (push_s) begin
                wdf_wr_ptr_r <= wdf_wr_ptr_r + 1'b1;
            end
            if (wr_acc_s) begin
                wdf_rd_ptr_r <= wdf_rd_ptr_r + 1'b1;
            end
            case ({push_s, wr_acc_s})
                2'b10:   wdf_cnt_r <= wdf_cnt_r + 1'b1;
                2'b01:   wdf_cnt_r <= wdf_cnt_r - 1'b1;
                default: wdf_cnt_r <= wdf_cnt_r;
            endcase
        end
    end

    // Storage survives reset; mask bit set means the byte is left untouched
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!wdf_mask_r[wdf_rd_ptr_r][b]) begin
                    mem_r[idx_s][b*8 +: 8] <= wdf_data_r[wdf_rd_ptr_r][b*8 +: 8];
                end
            end
        end
    end

    // Read data shift chain, kept in step with the valid chain below
    always_ff @(posedge clk) begin
        if (rd_acc_s) begin
            rd_dat_r[0] <= mem_r[idx_s];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            rd_dat_r[i] <= rd_dat_r[i-1];
        end
    end

    // Valid chain plus output register: valid rises RD_LAT edges after the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_r          <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            rd_vld_r[0] <= rd_acc_s;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_r[i] <= rd_vld_r[i-1];
            end
            app_rd_data_valid <= rd_vld_r[RD_LAT-1];
            if (rd_vld_r[RD_LAT-1]) begin
                app_rd_data <= rd_dat_r[RD_LAT-1];
            end
        end
    end

    // Sticky illegal-command flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err_r <= 1'b0;
        end else if (ill_acc_s) begin
            cmd_err_r <= 1'b1;
        end
    end

    assign phy_init_done = init_done_r;
    assign cmd_err       = cmd_err_r;

endmodule

// File: tb/tb_ddr_sim_memory_pl.sv
// Directed bench: instance 0 (RD_LAT=2, no stall, INIT=1000) runs a vector table and FIFO corners;
// instance 1 (RD_LAT=4, STALL_PERIOD=4, INIT=10) covers stalls, illegal commands and mid-read reset.
module tb_ddr_sim_memory_pl;

    logic        clk;
    logic        rst_v   [2];
    logic [2:0]  cmd_v   [2];
    logic        en_v    [2];
    logic [28:0] addr_v  [2];
    logic        rdy_v   [2];
    logic [63:0] wd_v    [2];
    logic [7:0]  wm_v    [2];
    logic        wren_v  [2];
    logic        wrdy_v  [2];
    logic [63:0] rd_v    [2];
    logic        rvld_v  [2];
    logic        done_v  [2];
    logic        err_v   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ddr_sim_memory_pl #(
        .DATA_W(64), .ADDR_W(29), .MEM_AW(12), .ADDR_SHIFT(2), .RD_LAT(2),
        .INIT_CYCLES(1000), .WDF_DEPTH(4), .STALL_PERIOD(0)
    ) dut (
        .clk(clk), .rst(rst_v[0]), .cmd(cmd_v[0]), .app_en(en_v[0]), .app_addr(addr_v[0]),
        .app_rdy(rdy_v[0]), .app_wdf_data(wd_v[0]), .app_wdf_mask(wm_v[0]),
        .app_wdf_wren(wren_v[0]), .app_wdf_rdy(wrdy_v[0]), .app_rd_data(rd_v[0]),
        .app_rd_data_valid(rvld_v[0]), .phy_init_done(done_v[0]), .cmd_err(err_v[0])
    );

    ddr_sim_memory_pl #(
        .DATA_W(64), .ADDR_W(29), .MEM_AW(12), .ADDR_SHIFT(2), .RD_LAT(4),
        .INIT_CYCLES(10), .WDF_DEPTH(4), .STALL_PERIOD(4)
    ) dut_s (
        .clk(clk), .rst(rst_v[1]), .cmd(cmd_v[1]), .app_en(en_v[1]), .app_addr(addr_v[1]),
        .app_rdy(rdy_v[1]), .app_wdf_data(wd_v[1]), .app_wdf_mask(wm_v[1]),
        .app_wdf_wren(wren_v[1]), .app_wdf_rdy(wrdy_v[1]), .app_rd_data(rd_v[1]),
        .app_rd_data_valid(rvld_v[1]), .phy_init_done(done_v[1]), .cmd_err(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        do_wr;
        logic [28:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [63:0] d, input logic [7:0] m);
        int n;
        n = 0;
        @(negedge clk);
        wren_v[s] = 1'b1; wd_v[s] = d; wm_v[s] = m;
        #1;
        while (!wrdy_v[s] && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check("push_rdy", 64'(wrdy_v[s]), 64'd1);
        @(negedge clk);
        wren_v[s] = 1'b0;
    endtask

    // Returns at the negedge following the accept edge (cyc == acc there)
    task automatic issue(input int s, input logic [2:0] c, input logic [28:0] a, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        en_v[s] = 1'b1; cmd_v[s] = c; addr_v[s] = a;
        #1;
        while (!rdy_v[s] && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check("issue_rdy", 64'(rdy_v[s]), 64'd1);
        acc = cyc + 1;
        @(negedge clk);
        en_v[s] = 1'b0;
    endtask

    task automatic read_chk(input int s, input logic [28:0] a, input logic [63:0] exp,
                            input int lat, input string nm);
        int acc, n;
        issue(s, 3'b001, a, acc);
        n = 0;
        while (!rvld_v[s] && n < 20) begin
            @(negedge clk); n++;
        end
        check({nm, "_lat"}, 64'(cyc - acc), 64'(lat));
        check({nm, "_data"}, rd_v[s], exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, first, early, nacc, low1, low2, vcnt, dbad, sawv, n;
        logic [63:0] dq [5];

        vecs[0] = '{1'b1, 29'h40,   64'hA5A5A5A5A5A5A5A5, 8'h00, 64'hA5A5A5A5A5A5A5A5};
        vecs[1] = '{1'b1, 29'h40,   64'h0000000000000011, 8'hFE, 64'hA5A5A5A5A5A5A511};
        vecs[2] = '{1'b1, 29'h80,   64'h1122334455667788, 8'h00, 64'h1122334455667788};
        vecs[3] = '{1'b1, 29'h80,   64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'hFFFFFFFF55667788};
        vecs[4] = '{1'b1, 29'h4000, 64'hDEADBEEFCAFEF00D, 8'h00, 64'hDEADBEEFCAFEF00D};
        vecs[5] = '{1'b0, 29'h0,    64'h0,                8'h00, 64'hDEADBEEFCAFEF00D};
        vecs[6] = '{1'b1, 29'h3FFC, 64'h0102030405060708, 8'h00, 64'h0102030405060708};
        vecs[7] = '{1'b1, 29'h3FFC, 64'hAAAAAAAAAAAAAAAA, 8'h55, 64'hAA02AA04AA06AA08};
        vecs[8] = '{1'b0, 29'h3FFF, 64'h0,                8'h00, 64'hAA02AA04AA06AA08};
        dq[0] = 64'h1000000000000001; dq[1] = 64'h2000000000000002;
        dq[2] = 64'h3000000000000003; dq[3] = 64'h4000000000000004;
        dq[4] = 64'h5000000000000005;

        for (int s = 0; s < 2; s++) begin
            rst_v[s] = 1'b1; cmd_v[s] = 3'b000; en_v[s] = 1'b0; addr_v[s] = '0;
            wd_v[s] = '0; wm_v[s] = '0; wren_v[s] = 1'b0;
        end

        // Reset and init timing
        repeat (3) @(negedge clk);
        check("rst_flags", {59'd0, rdy_v[0], wrdy_v[0], rvld_v[0], done_v[0], err_v[0]}, 64'd0);
        check("rst_rd_data", rd_v[0], 64'd0);
        rst_v[0] = 1'b0;
        first = 0; early = 0;
        for (int k = 1; k <= 1010; k++) begin
            @(negedge clk);
            if (done_v[0] && first == 0) first = k;
            if (!done_v[0] && (rdy_v[0] || wrdy_v[0])) early = 1;
        end
        check("init_edge", 64'(first), 64'd1000);
        check("init_early_rdy", 64'(early), 64'd0);
        check("rdy_after_init", {62'd0, rdy_v[0], wrdy_v[0]}, 64'd3);

        // Vector table: optional masked write then read-back
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) begin
                push(0, vecs[i].data, vecs[i].mask);
                issue(0, 3'b000, vecs[i].addr, acc);
            end
            read_chk(0, vecs[i].addr, vecs[i].exp, 2, $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("hold_valid", 64'(rvld_v[0]), 64'd0);
        check("hold_data", rd_v[0], vecs[8].exp);

        // Write command with empty FIFO; same-cycle push does not satisfy it
        @(negedge clk);
        en_v[0] = 1'b1; cmd_v[0] = 3'b000; addr_v[0] = 29'h200;
        #1 check("empty_wr_rdy", 64'(rdy_v[0]), 64'd0);
        @(negedge clk);
        wren_v[0] = 1'b1; wd_v[0] = 64'h5555555555555555; wm_v[0] = 8'h00;
        #1 check("nobypass_rdy", 64'(rdy_v[0]), 64'd0);
        @(negedge clk);
        wren_v[0] = 1'b0;
        #1 check("wr_after_push_rdy", 64'(rdy_v[0]), 64'd1);
        @(negedge clk);
        en_v[0] = 1'b0;
        read_chk(0, 29'h200, 64'h5555555555555555, 2, "emptywr");

        // Fill FIFO, pop, simultaneous push+pop, drain, verify order
        for (int i = 0; i < 4; i++) push(0, dq[i], 8'h00);
        #1 check("full_wdf_rdy", 64'(wrdy_v[0]), 64'd0);
        issue(0, 3'b000, 29'h100, acc);
        #1 check("wdf_rdy_after_pop", 64'(wrdy_v[0]), 64'd1);
        @(negedge clk);
        wren_v[0] = 1'b1; wd_v[0] = dq[4]; wm_v[0] = 8'h00;
        en_v[0] = 1'b1; cmd_v[0] = 3'b000; addr_v[0] = 29'h104;
        #1 check("pushpop_rdys", {62'd0, rdy_v[0], wrdy_v[0]}, 64'd3);
        @(negedge clk);
        wren_v[0] = 1'b0; en_v[0] = 1'b0;
        for (int i = 2; i < 5; i++) issue(0, 3'b000, 29'(29'h100 + 4 * i), acc);
        @(negedge clk);
        en_v[0] = 1'b1; cmd_v[0] = 3'b000;
        #1 check("drained_rdy", 64'(rdy_v[0]), 64'd0);
        en_v[0] = 1'b0;
        for (int i = 0; i < 5; i++)
            read_chk(0, 29'(29'h100 + 4 * i), dq[i], 2, $sformatf("fifo%0d", i));

        // Instance 1: init, write, wrapped-address read
        @(negedge clk);
        rst_v[1] = 1'b0;
        n = 0;
        while (!done_v[1] && n < 40) begin @(negedge clk); n++; end
        check("b_init", 64'(done_v[1]), 64'd1);
        push(1, 64'h0123456789ABCDEF, 8'h00);
        issue(1, 3'b000, 29'h0, acc);
        read_chk(1, 29'h4000, 64'h0123456789ABCDEF, 4, "b_wrap");

        // Read held for 8 cycles across stalls
        @(negedge clk);
        en_v[1] = 1'b1; cmd_v[1] = 3'b001; addr_v[1] = 29'h0;
        nacc = 0; low1 = -1; low2 = -1; vcnt = 0; dbad = 0;
        for (int k = 0; k < 8; k++) begin
            if (rvld_v[1]) begin
                vcnt++;
                if (rd_v[1] !== 64'h0123456789ABCDEF) dbad++;
            end
            #1;
            if (rdy_v[1]) nacc++;
            else if (low1 < 0) low1 = k;
            else low2 = k;
            @(negedge clk);
        end
        en_v[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (rvld_v[1]) begin
                vcnt++;
                if (rd_v[1] !== 64'h0123456789ABCDEF) dbad++;
            end
            @(negedge clk);
        end
        check("stall_accepts", 64'(nacc), 64'd6);
        check("stall_spacing", 64'(low2 - low1), 64'd4);
        check("stall_valids", 64'(vcnt), 64'd6);
        check("stall_data_bad", 64'(dbad), 64'd0);

        // Illegal command: flag set, no memory or FIFO effect
        push(1, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        check("err_before", 64'(err_v[1]), 64'd0);
        issue(1, 3'b101, 29'h0, acc);
        check("err_set", 64'(err_v[1]), 64'd1);
        read_chk(1, 29'h0, 64'h0123456789ABCDEF, 4, "b_ill_mem");
        issue(1, 3'b000, 29'h8, acc);
        read_chk(1, 29'h8, 64'hFFFFFFFFFFFFFFFF, 4, "b_ill_fifo");

        // Reset while a read is in flight
        issue(1, 3'b001, 29'h0, acc);
        rst_v[1] = 1'b1;
        #1 check("b_rst_flags", {59'd0, rdy_v[1], wrdy_v[1], rvld_v[1], done_v[1], err_v[1]}, 64'd0);
        @(negedge clk);
        rst_v[1] = 1'b0;
        sawv = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rvld_v[1]) sawv = 1;
        end
        check("rst_drop_valid", 64'(sawv), 64'd0);
        check("err_cleared", 64'(err_v[1]), 64'd0);
        n = 0;
        while (!done_v[1] && n < 40) begin @(negedge clk); n++; end
        read_chk(1, 29'h0, 64'h0123456789ABCDEF, 4, "b_retained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
